// File: rtl/deglitcher_sync.sv
`default_nettype none
// ============================================================================
//  Module      : deglitcher_sync
//  Description : Clocked multi-channel deglitcher. Each channel has an input
//                synchroniser and a small FSM that accepts an edge only after
//                FilterLen agreeing samples. The rise and fall directions can
//                each be filtered or passed straight through. Per-channel
//                edge strobes and a shared saturating glitch counter are
//                also provided.
//  Revision    : 1.0 - initial release
// ============================================================================
module deglitcher_sync #(
    parameter int N_CH        = 8,
    parameter int CNT_W       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_W    = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [1:0]          Mode,
    input  logic [CNT_W-1:0]    FilterLen,
    input  logic [N_CH-1:0]     In,
    output logic [N_CH-1:0]     Out,
    output logic [N_CH-1:0]     RiseStb,
    output logic [N_CH-1:0]     FallStb,
    output logic [GLITCH_W-1:0] GlitchCnt,
    input  logic                GlitchClr
);

    // Per-channel filter states; S_HI and Q_LO both drive the output high.
    typedef enum logic [1:0] {
        S_LO = 2'd0,
        Q_HI = 2'd1,
        S_HI = 2'd2,
        Q_LO = 2'd3
    } state_t;

    localparam logic [1:0] C_MODE_RISE   = 2'b00;
    localparam logic [1:0] C_MODE_FALL   = 2'b01;
    localparam logic [1:0] C_MODE_BOTH   = 2'b10;
    localparam logic [1:0] C_MODE_BYPASS = 2'b11;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   C_INC_ONE = {{CNT_W{1'b0}}, 1'b1};

    // The popcount of one cycle's events may exceed the counter width when
    // GLITCH_W is small, so the sum is formed wide enough for either operand.
    localparam int PC_W  = $clog2(N_CH + 1);
    localparam int SUM_W = ((GLITCH_W > PC_W) ? GLITCH_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] C_GMAX =
        {{(SUM_W-GLITCH_W){1'b0}}, {GLITCH_W{1'b1}}};

    logic [N_CH-1:0]     w_s;
    logic [N_CH-1:0]     w_glitch_vec;
    logic [CNT_W-1:0]    w_flen;
    logic                w_flen_le1;
    logic                w_rise_q;
    logic                w_fall_q;
    logic                w_bypass;
    logic [PC_W-1:0]     w_pc;
    logic [SUM_W-1:0]    w_gsum;
    logic [GLITCH_W-1:0] w_gcnt_nx;
    logic [GLITCH_W-1:0] r_gcnt;

    // ------------------------------------------------------------------
    // Input synchroniser (bypassed entirely when SYNC_STAGES is 0)
    // ------------------------------------------------------------------
    if (SYNC_STAGES > 0) begin : g_sync
        logic [N_CH-1:0] r_sync [SYNC_STAGES];

        // Shift the raw inputs through the synchroniser chain.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= '0;
                end
            end else begin
                r_sync[0] <= In;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
        assign w_s = In;
    end

    // ------------------------------------------------------------------
    // Shared mode / length decode
    // ------------------------------------------------------------------
    assign w_flen     = (FilterLen == '0) ? C_CNT_ONE : FilterLen;
    assign w_flen_le1 = (w_flen == C_CNT_ONE);
    assign w_rise_q   = (Mode == C_MODE_RISE) || (Mode == C_MODE_BOTH);
    assign w_fall_q   = (Mode == C_MODE_FALL) || (Mode == C_MODE_BOTH);
    assign w_bypass   = (Mode == C_MODE_BYPASS);

    // ------------------------------------------------------------------
    // Per-channel filter FSM
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nx;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nx;
        logic [CNT_W:0]   w_cnt_inc;
        logic             w_q_done;
        logic             w_glitch;
        logic             w_out_nx;
        logic             r_out;
        logic             r_rise;
        logic             r_fall;

        assign w_cnt_inc = {1'b0, r_cnt} + C_INC_ONE;
        assign w_q_done  = (w_cnt_inc >= {1'b0, w_flen});

        // Next-state, qualify counter and glitch-event decode.
        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_glitch   = 1'b0;
            if (!Enable) begin
                w_state_nx = S_LO;
                w_cnt_nx   = '0;
            end else if (w_bypass) begin
                w_state_nx = w_s[i] ? S_HI : S_LO;
                w_cnt_nx   = '0;
            end else begin
                case (r_state)
                    S_LO: begin
                        if (w_s[i]) begin
                            if (!w_rise_q || w_flen_le1) begin
                                w_state_nx = S_HI;
                                w_cnt_nx   = '0;
                            end else begin
                                w_state_nx = Q_HI;
                                w_cnt_nx   = C_CNT_ONE;
                            end
                        end
                    end
                    Q_HI: begin
                        if (!w_s[i]) begin
                            w_state_nx = S_LO;
                            w_cnt_nx   = '0;
                            w_glitch   = 1'b1;
                        end else if (!w_rise_q || w_q_done) begin
                            w_state_nx = S_HI;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx   = w_cnt_inc[CNT_W-1:0];
                        end
                    end
                    S_HI: begin
                        if (!w_s[i]) begin
                            if (!w_fall_q || w_flen_le1) begin
                                w_state_nx = S_LO;
                                w_cnt_nx   = '0;
                            end else begin
                                w_state_nx = Q_LO;
                                w_cnt_nx   = C_CNT_ONE;
                            end
                        end
                    end
                    Q_LO: begin
                        if (w_s[i]) begin
                            w_state_nx = S_HI;
                            w_cnt_nx   = '0;
                            w_glitch   = 1'b1;
                        end else if (!w_fall_q || w_q_done) begin
                            w_state_nx = S_LO;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx   = w_cnt_inc[CNT_W-1:0];
                        end
                    end
                    default: begin
                        w_state_nx = S_LO;
                        w_cnt_nx   = '0;
                    end
                endcase
            end
        end

        assign w_out_nx = (w_state_nx == S_HI) || (w_state_nx == Q_LO);

        // State, counter, output and strobe registers; strobes are
        // suppressed while disabled so forcing Out low never emits FallStb.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_state <= S_LO;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                r_out   <= w_out_nx;
                r_rise  <= Enable &  w_out_nx & ~r_out;
                r_fall  <= Enable & ~w_out_nx &  r_out;
            end
        end

        assign w_glitch_vec[i] = w_glitch;
        assign Out[i]          = r_out;
        assign RiseStb[i]      = r_rise;
        assign FallStb[i]      = r_fall;
    end

    // ------------------------------------------------------------------
    // Shared saturating glitch counter
    // ------------------------------------------------------------------

    // Count this cycle's glitch events across all channels.
    always_comb begin
        w_pc = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_pc = w_pc + PC_W'(w_glitch_vec[k]);
        end
    end

    // A clear restarts from zero but still absorbs this cycle's events.
    always_comb begin
        w_gsum    = (GlitchClr ? '0 : SUM_W'(r_gcnt)) + SUM_W'(w_pc);
        w_gcnt_nx = (w_gsum > C_GMAX) ? {GLITCH_W{1'b1}} : w_gsum[GLITCH_W-1:0];
    end

    // Glitch counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gcnt <= '0;
        end else begin
            r_gcnt <= w_gcnt_nx;
        end
    end

    assign GlitchCnt = r_gcnt;

endmodule
`default_nettype wire
